// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

  // Default widths for register addresses and multi-cycle op lengths.
  localparam int REG_AW_DEF   = 5;
  localparam int MC_CNT_W_DEF = 6;

  // Writes to register 0 are discarded, so a load targeting it never creates a hazard.
  localparam int unsigned ZERO_REG = 0;

  // Controller states.
  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_mc_counter.sv
// Countdown for multi-cycle EX ops: load on entry, decrement each busy cycle, flag the last one.
// Latency: load/decrement take effect on the next clock; 'last' is combinational from the count.
// Backpressure: none; the parent FSM sequences load and decrement.
//
// Ports:
//   clk, rst  clock and synchronous active-high reset (count returns to 0)
//   load      capture load_val
//   load_val  number of busy cycles still owed, including the first busy cycle
//   dec       consume one busy cycle
//   last      the current busy cycle is the final one
import hazard_ctrl_pkg::*;

module hazard_mc_counter #(
  parameter int MC_CNT_W = MC_CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [MC_CNT_W-1:0] load_val,
  input  logic                dec,
  output logic                last
);

  logic [MC_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - MC_CNT_W'(1);
    end
  end

  // A count of 1 (or a defensive 0) means this busy cycle is the final one.
  assign last = (cnt <= MC_CNT_W'(1));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage core: PC and IF/ID, ID/EX, EX/MEM hold/flush.
// Latency: Mealy outputs, decided in the same cycle as the hazard; state advances each clock.
// Backpressure: a multi-cycle EX op freezes the front end until it completes; no other stall source.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset (all outputs 0 while high)
//   id_rs/id_rt, id_uses_rs/rt    ID-stage source registers and their use flags
//   id_jump                       ID instruction is an unconditional jump
//   ex_mem_read, ex_rd            EX instruction is a load, and its destination
//   ex_branch_taken               EX branch resolved taken
//   mc_start, mc_cycles           first EX cycle of a multi-cycle op and its total EX cycles
//   pc_hold, if_id_hold/flush,
//   id_ex_hold/flush, ex_mem_flush pipeline register controls
//   mc_busy                       multi-cycle op in progress (after its first cycle)
//   cnt_lu_stall, cnt_mc_stall,
//   cnt_flush                     saturating event counters, present only with HAZARD_STATS_EN
//
// A multi-cycle op of N EX cycles stalls the front end for N-1 cycles: the entry cycle in RUN
// plus N-2 cycles in MC_BUSY. An op of 2 cycles therefore stalls only on its entry cycle.
import hazard_ctrl_pkg::*;

module hazard_stall_ctrl #(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int MC_CNT_W = MC_CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_AW-1:0]   id_rs,
  input  logic [REG_AW-1:0]   id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                id_jump,
  input  logic                ex_mem_read,
  input  logic [REG_AW-1:0]   ex_rd,
  input  logic                ex_branch_taken,
  input  logic                mc_start,
  input  logic [MC_CNT_W-1:0] mc_cycles,
  output logic                pc_hold,
  output logic                if_id_hold,
  output logic                if_id_flush,
  output logic                id_ex_hold,
  output logic                id_ex_flush,
  output logic                ex_mem_flush,
`ifdef HAZARD_STATS_EN
  output logic [31:0]         cnt_lu_stall,
  output logic [31:0]         cnt_mc_stall,
  output logic [31:0]         cnt_flush,
`endif
  output logic                mc_busy
);

  hz_state_t state, state_nxt;

  logic lu;
  logic mc_go;
  logic mc_enter;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_last;
  logic [MC_CNT_W-1:0] cnt_load_val;

  // Which cause drove the outputs this cycle.
  logic ev_lu;
  logic ev_mc;
  logic ev_flush;

  assign lu = ex_mem_read && (ex_rd != REG_AW'(ZERO_REG)) &&
              ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

  // Ops shorter than 2 cycles do not stall at all; a 2-cycle op stalls only on entry.
  assign mc_go        = mc_start && (mc_cycles >= MC_CNT_W'(2));
  assign mc_enter     = mc_start && (mc_cycles >= MC_CNT_W'(3));
  assign cnt_load_val = mc_cycles - MC_CNT_W'(2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_hold   = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mc_busy      = 1'b0;
    ev_lu        = 1'b0;
    ev_mc        = 1'b0;
    ev_flush     = 1'b0;

    case (state)
      RUN: begin
        if (mc_go) begin
          // A simultaneous taken branch is illegal and ignored here.
          pc_hold      = 1'b1;
          if_id_hold   = 1'b1;
          id_ex_hold   = 1'b1;
          ex_mem_flush = 1'b1;
          ev_mc        = 1'b1;
          if (mc_enter) begin
            cnt_load  = 1'b1;
            state_nxt = MC_BUSY;
          end
        end else if (ex_branch_taken) begin
          // Squashes both younger instructions, including any load-use victim or jump.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          ev_flush    = 1'b1;
        end else if (lu) begin
          // One bubble; a jump in ID is re-presented next cycle and handled then.
          pc_hold     = 1'b1;
          if_id_hold  = 1'b1;
          id_ex_flush = 1'b1;
          ev_lu       = 1'b1;
        end else if (id_jump) begin
          if_id_flush = 1'b1;
          ev_flush    = 1'b1;
        end
      end

      MC_BUSY: begin
        // Every other input is ignored until the op drains.
        pc_hold      = 1'b1;
        if_id_hold   = 1'b1;
        id_ex_hold   = 1'b1;
        ex_mem_flush = 1'b1;
        mc_busy      = 1'b1;
        ev_mc        = 1'b1;
        if (cnt_last) begin
          state_nxt = RUN;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      default: state_nxt = RUN;
    endcase

    if (rst) begin
      pc_hold      = 1'b0;
      if_id_hold   = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_hold   = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mc_busy      = 1'b0;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      ev_lu        = 1'b0;
      ev_mc        = 1'b0;
      ev_flush     = 1'b0;
    end
  end

  hazard_mc_counter #(
    .MC_CNT_W (MC_CNT_W)
  ) u_mc_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lu_stall <= '0;
      cnt_mc_stall <= '0;
      cnt_flush    <= '0;
    end else begin
      if (ev_lu && (cnt_lu_stall != '1)) cnt_lu_stall <= cnt_lu_stall + 32'd1;
      if (ev_mc && (cnt_mc_stall != '1)) cnt_mc_stall <= cnt_mc_stall + 32'd1;
      if (ev_flush && (cnt_flush != '1)) cnt_flush    <= cnt_flush + 32'd1;
    end
  end
`else
  // Cause flags only feed the optional counters.
  logic ev_unused;
  assign ev_unused = ev_lu ^ ev_mc ^ ev_flush;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: table of single-cycle RUN vectors plus
// hand-written multi-cycle sequences, expectations queued on drive and popped on sample.
// Output vector bit order: {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_flush, mc_busy}.
module tb_hazard_stall_ctrl;

  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_LU   = 7'b1100100;
  localparam logic [6:0] O_BR   = 7'b0010100;
  localparam logic [6:0] O_JMP  = 7'b0010000;
  localparam logic [6:0] O_MCR  = 7'b1101010;
  localparam logic [6:0] O_MCB  = 7'b1101011;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       jump;
    logic       mr;
    logic [4:0] rd;
    logic       br;
    logic       ms;
    logic [5:0] mcc;
  } vec_t;

  typedef struct {
    vec_t       v;
    logic [6:0] exp;
    string      name;
  } row_t;

  typedef struct {
    logic [6:0] exp;
    string      name;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, id_jump, ex_mem_read, ex_branch_taken, mc_start;
  logic [5:0] mc_cycles;
  logic       pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_flush, mc_busy;
`ifdef HAZARD_STATS_EN
  logic [31:0] cnt_lu_stall, cnt_mc_stall, cnt_flush;
`endif

  logic [6:0] outs;
  assign outs = {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_flush, mc_busy};

  int n_cmp = 0;
  int n_bad = 0;
  sb_t sb[$];

  hazard_stall_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_jump         (id_jump),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mc_start        (mc_start),
    .mc_cycles       (mc_cycles),
    .pc_hold         (pc_hold),
    .if_id_hold      (if_id_hold),
    .if_id_flush     (if_id_flush),
    .id_ex_hold      (id_ex_hold),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_flush    (ex_mem_flush),
`ifdef HAZARD_STATS_EN
    .cnt_lu_stall    (cnt_lu_stall),
    .cnt_mc_stall    (cnt_mc_stall),
    .cnt_flush       (cnt_flush),
`endif
    .mc_busy         (mc_busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic j,
                               input logic mr, input logic [4:0] rd, input logic br,
                               input logic ms, input logic [5:0] mcc);
    vec_t v;
    v.rst = r; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.jump = j;
    v.mr = mr; v.rd = rd; v.br = br; v.ms = ms; v.mcc = mcc;
    return v;
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, queue the expectation, sample 2 ns later.
  task automatic apply(input vec_t v, input logic [6:0] exp, input string name);
    sb_t e;
    logic [6:0] a;
    @(negedge clk);
    rst = v.rst; id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
    id_jump = v.jump; ex_mem_read = v.mr; ex_rd = v.rd; ex_branch_taken = v.br;
    mc_start = v.ms; mc_cycles = v.mcc;
    if (v.ms && v.br && !v.rst)
      $display("note: %s drives illegal mc_start with ex_branch_taken", name);
    e.exp = exp; e.name = name;
    sb.push_back(e);
    #2;
    a = outs;
    e = sb.pop_front();
    check(e.name, a, e.exp);
    n_cmp++;
    if ((a[5] && a[4]) || (a[3] && a[2])) begin
      n_bad++;
      $display("FAIL %s_inv: hold and flush together on one register, outputs %b", e.name, a);
    end
  endtask

  vec_t IDLE;
  row_t tbl[14];

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rs = 0; id_uses_rt = 0; id_jump = 0;
    ex_mem_read = 0; ex_rd = '0; ex_branch_taken = 0; mc_start = 0; mc_cycles = '0;
    IDLE = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //               rst rs  rt urs urt j  mr rd  br ms mcc
    tbl[0]  = '{mkv(1,  5,  0, 1,  0,  1, 1, 5,  1, 1, 4),  O_NONE, "reset_outputs"};
    tbl[1]  = '{IDLE,                                      O_NONE, "idle"};
    tbl[2]  = '{mkv(0,  5,  0, 1,  0,  0, 1, 5,  0, 0, 0),  O_LU,   "lu_rs"};
    tbl[3]  = '{IDLE,                                      O_NONE, "lu_bubble"};
    tbl[4]  = '{mkv(0,  0,  0, 1,  0,  0, 1, 0,  0, 0, 0),  O_NONE, "lu_r0"};
    tbl[5]  = '{mkv(0,  1,  7, 0,  1,  0, 1, 7,  0, 0, 0),  O_LU,   "lu_rt"};
    tbl[6]  = '{mkv(0,  5,  0, 0,  0,  0, 1, 5,  0, 0, 0),  O_NONE, "lu_unused_src"};
    tbl[7]  = '{mkv(0,  5,  0, 1,  0,  0, 0, 5,  0, 0, 0),  O_NONE, "no_load"};
    tbl[8]  = '{mkv(0,  5,  0, 1,  0,  0, 1, 5,  1, 0, 0),  O_BR,   "branch_over_lu"};
    tbl[9]  = '{mkv(0,  0,  0, 0,  0,  1, 0, 0,  0, 0, 0),  O_JMP,  "jump"};
    tbl[10] = '{mkv(0,  0,  0, 0,  0,  1, 0, 0,  1, 0, 0),  O_BR,   "branch_over_jump"};
    tbl[11] = '{mkv(0,  0,  0, 0,  0,  0, 0, 0,  0, 1, 1),  O_NONE, "mc_len1"};
    tbl[12] = '{mkv(0,  0,  0, 0,  0,  0, 0, 0,  1, 1, 0),  O_BR,   "mc_len0_branch"};
    tbl[13] = '{mkv(0,  3,  0, 1,  0,  0, 1, 3,  0, 1, 1),  O_LU,   "mc_len1_lu"};

    apply(tbl[0].v, tbl[0].exp, "reset_hold");
    for (int i = 0; i < 14; i++) apply(tbl[i].v, tbl[i].exp, tbl[i].name);

    // 4-cycle op: 3 stall cycles, busy on cycles 2-3, back in RUN on cycle 4.
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4), O_MCR,  "mc4_c1");
    apply(IDLE,                                 O_MCB,  "mc4_c2");
    apply(IDLE,                                 O_MCB,  "mc4_c3");
    apply(mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), O_JMP,  "mc4_c4_run");

    // 2-cycle op: stalls only on its entry cycle.
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2), O_MCR,  "mc2_c1");
    apply(IDLE,                                 O_NONE, "mc2_c2");

    // 5-cycle op with hazards pulsed during busy: ignored, countdown unaffected.
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5), O_MCR,  "mc5_c1");
    apply(mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), O_MCB,  "mc5_jump_ign");
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_MCB,  "mc5_br_ign");
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9), O_MCB,  "mc5_restart_ign");
    apply(IDLE,                                 O_NONE, "mc5_done");

    // Illegal mc_start with taken branch: branch dropped, 3-cycle op proceeds.
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3), O_MCR,  "mc_br_c1");
    apply(IDLE,                                 O_MCB,  "mc_br_c2");
    apply(IDLE,                                 O_NONE, "mc_br_done");

    // Reset in the second busy cycle aborts the op.
    apply(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6), O_MCR,  "rst_mc_c1");
    apply(IDLE,                                 O_MCB,  "rst_mc_c2");
    apply(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_NONE, "rst_mc_c3");
    apply(IDLE,                                 O_NONE, "rst_mc_after");
    apply(mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), O_JMP,  "rst_mc_jump");

    // Jump deferred behind a load-use stall.
    apply(mkv(0, 9, 0, 1, 0, 1, 1, 9, 0, 0, 0), O_LU,   "jdef_c1");
    apply(mkv(0, 9, 0, 1, 0, 1, 0, 0, 0, 0, 0), O_JMP,  "jdef_c2");
    apply(IDLE,                                 O_NONE, "jdef_c3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
